fetch_pc_sequencer: RTL and testbench
=====================================

Name: fetch_pc_sequencer

Overview:
Owns the fetch PC register and picks the next fetch address each cycle from five sources: mispredict recovery, jump redirect, jump-stall hold, backend-stall hold, and predicted branch or sequential advance. It sits between the jump handler, branch predictor and retire/mispredict logic on one side, and the I-cache fetch port on the other. It sequences refill bubbles after redirects and holds fetch while a register-based jump waits for its base.

Parameters:
FETCH_WIDTH, 4, instructions per fetch bundle; sequential advance is pc+FETCH_WIDTH
FLUSH_CYCLES, 2, bubble cycles after mispredict redirect (1..7)
RESET_PC, 16'h0000, PC loaded on reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
has_mispredict  in  1  backend mispredict, highest priority
mispredict_pc  in  16  recovery address
jump_redirect  in  1  jump handler has a resolved target this cycle
jump_target  in  16  jump target, valid with jump_redirect
jump_stall  in  1  register-based jump is waiting for its base
backend_stall  in  1  decode/issue cannot accept a bundle
bp_taken  in  1  predictor says the current bundle holds a taken branch
bp_target  in  16  predicted target
fetch_pc  out  16  current fetch address (registered)
fetch_valid  out  1  bundle at fetch_pc is to be used downstream
fetch_kill  out  1  squash the bundle currently in decode (registered)
seq_state  out  2  0=RUN 1=JWAIT 2=FLUSH 3=HOLD
redirect_cnt  out  16  count of mispredict and jump redirects, wraps at 16'hFFFF->0

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, fetch_valid=0, fetch_kill=0, state=RUN, flush counter=0, redirect_cnt=0. The first cycle after deassertion has fetch_valid=1.
- Next-PC priority, evaluated every cycle:
  1. has_mispredict: fetch_pc<=mispredict_pc; state<=FLUSH; flush_ctr<=FLUSH_CYCLES; fetch_kill<=1; redirect_cnt+1.
  2. jump_redirect: fetch_pc<=jump_target; state<=RUN; fetch_kill<=1; redirect_cnt+1.
  3. jump_stall: fetch_pc holds; state<=JWAIT.
  4. backend_stall: fetch_pc holds; state<=HOLD.
  5. bp_taken: fetch_pc<=bp_target.
  6. Otherwise: fetch_pc<=fetch_pc+FETCH_WIDTH, mod 2^16 (16'hFFFC+4 wraps to 0).
- fetch_kill is a one-cycle pulse, registered, one cycle after a redirect.
- FLUSH: fetch_valid=0 while flush_ctr!=0. flush_ctr decrements each cycle and fetch_pc holds. When it reaches 0, state<=RUN. Priorities 1 and 2 still preempt: a new mispredict reloads the counter; a jump_redirect leaves FLUSH immediately. jump_stall, backend_stall and bp_taken are ignored during FLUSH.
- JWAIT: fetch_valid=0. Leaves on jump_redirect (to RUN) or on has_mispredict (to FLUSH). If jump_stall drops without a redirect, go to RUN with fetch_pc held.
- HOLD: fetch_valid=1, fetch_pc held. Return to RUN when backend_stall=0.
- RUN: fetch_valid=1.
- fetch_valid is combinational from state and flush_ctr.
- Simultaneous events:
  - Mispredict with jump_redirect: mispredict wins, and redirect_cnt increments once.
  - jump_redirect with jump_stall: redirect wins.
  - Mispredict while rst=1: reset wins.

Decomposition:
- Shared package fetch_pkg: the state encoding (RUN/JWAIT/FLUSH/HOLD), the 16-bit pc_t typedef, and the FETCH_WIDTH default.
- Sub-module fetch_next_pc_mux: purely combinational priority select that produces next_pc and a redirect flag. State, counters and registers stay in the top.

Test Plan:
- Release reset with no events -> fetch_pc follows 0,4,8,12, fetch_valid=1 from the first cycle, seq_state=0.
- At fetch_pc=16'h0010, pulse has_mispredict with mispredict_pc=16'h0100 -> next cycle: fetch_pc=16'h0100, fetch_kill=1, fetch_valid=0 for 2 cycles, then fetch_pc=0104 with valid=1; redirect_cnt=1.
- Hold jump_stall 3 cycles, then jump_redirect with target 16'h0200 -> seq_state=1 and valid=0 with pc frozen; then fetch_pc=0200, fetch_kill pulses, state RUN.
- During FLUSH (ctr=1), assert has_mispredict again with 16'h0300 -> counter reloaded to 2, fetch_pc=0300, redirect_cnt increments.
- Same cycle: has_mispredict(0x0400), jump_redirect(0x0500), bp_taken(0x0600) -> fetch_pc=0x0400, redirect_cnt +1 only.
- Start at fetch_pc=16'hFFFC with no events -> next pc 16'h0000. Assert rst asynchronously mid-JWAIT -> immediate fetch_pc=RESET_PC, state RUN, counters cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types for the fetch PC sequencer (PC type, state codes).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef logic [15:0] pc_t;

    localparam int unsigned FETCH_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_JWAIT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_next_pc_mux.sv
// ============================================================================
//  Module   : fetch_next_pc_mux
//  Purpose  : Combinational priority select of the next fetch PC.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_next_pc_mux
    import fetch_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = FETCH_WIDTH_DEFAULT
) (
    input  seq_state_e i_state,
    input  pc_t        i_fetch_pc,
    input  logic       i_has_mispredict,
    input  pc_t        i_mispredict_pc,
    input  logic       i_jump_redirect,
    input  pc_t        i_jump_target,
    input  logic       i_jump_stall,
    input  logic       i_backend_stall,
    input  logic       i_bp_taken,
    input  pc_t        i_bp_target,
    output pc_t        o_next_pc,
    output logic       o_redirect
);

    localparam pc_t C_STEP = pc_t'(FETCH_WIDTH);

    always_comb begin
        o_next_pc  = i_fetch_pc;
        o_redirect = 1'b0;
        if (i_has_mispredict) begin
            o_next_pc  = i_mispredict_pc;
            o_redirect = 1'b1;
        end else if (i_jump_redirect) begin
            o_next_pc  = i_jump_target;
            o_redirect = 1'b1;
        end else if (i_state == ST_FLUSH || i_state == ST_JWAIT) begin
            // Bubble states freeze the PC; stalls and predictions do not apply.
            o_next_pc  = i_fetch_pc;
        end else if (i_jump_stall || i_backend_stall) begin
            o_next_pc  = i_fetch_pc;
        end else if (i_bp_taken) begin
            o_next_pc  = i_bp_target;
        end else begin
            o_next_pc  = i_fetch_pc + C_STEP;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_sequencer.sv
// ============================================================================
//  Module   : fetch_pc_sequencer
//  Purpose  : Fetch PC register, redirect/stall sequencing and refill bubbles.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_pc_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH  = FETCH_WIDTH_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [15:0] RESET_PC     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        has_mispredict,
    input  logic [15:0] mispredict_pc,
    input  logic        jump_redirect,
    input  logic [15:0] jump_target,
    input  logic        jump_stall,
    input  logic        backend_stall,
    input  logic        bp_taken,
    input  logic [15:0] bp_target,
    output logic [15:0] fetch_pc,
    output logic        fetch_valid,
    output logic        fetch_kill,
    output logic [1:0]  seq_state,
    output logic [15:0] redirect_cnt
);

    localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    seq_state_e  state_q, state_d;
    pc_t         pc_q, pc_d;
    logic [2:0]  flush_ctr_q, flush_ctr_d;
    logic        kill_q, kill_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;

    pc_t         w_next_pc;
    logic        w_redirect;

    fetch_next_pc_mux #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_mux (
        .i_state          (state_q),
        .i_fetch_pc       (pc_q),
        .i_has_mispredict (has_mispredict),
        .i_mispredict_pc  (mispredict_pc),
        .i_jump_redirect  (jump_redirect),
        .i_jump_target    (jump_target),
        .i_jump_stall     (jump_stall),
        .i_backend_stall  (backend_stall),
        .i_bp_taken       (bp_taken),
        .i_bp_target      (bp_target),
        .o_next_pc        (w_next_pc),
        .o_redirect       (w_redirect)
    );

    always_comb begin
        state_d        = state_q;
        flush_ctr_d    = flush_ctr_q;
        pc_d           = w_next_pc;
        kill_d         = w_redirect;
        redirect_cnt_d = redirect_cnt_q + {15'd0, w_redirect};
        if (has_mispredict) begin
            state_d     = ST_FLUSH;
            flush_ctr_d = C_FLUSH_LOAD;
        end else if (jump_redirect) begin
            state_d     = ST_RUN;
            flush_ctr_d = 3'd0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (flush_ctr_q > 3'd1) begin
                        flush_ctr_d = flush_ctr_q - 3'd1;
                    end else begin
                        flush_ctr_d = 3'd0;
                        state_d     = ST_RUN;
                    end
                end
                ST_JWAIT: state_d = jump_stall ? ST_JWAIT : ST_RUN;
                default: begin
                    if (jump_stall)         state_d = ST_JWAIT;
                    else if (backend_stall) state_d = ST_HOLD;
                    else                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_PC;
            flush_ctr_q    <= 3'd0;
            kill_q         <= 1'b0;
            redirect_cnt_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            flush_ctr_q    <= flush_ctr_d;
            kill_q         <= kill_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    // Valid is held low while reset is asserted so the first usable bundle
    // appears only after release.
    always_comb begin
        fetch_valid = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN, ST_HOLD: fetch_valid = 1'b1;
                ST_FLUSH:        fetch_valid = (flush_ctr_q == 3'd0);
                default:         fetch_valid = 1'b0;
            endcase
        end
    end

    assign fetch_pc     = pc_q;
    assign fetch_kill   = kill_q;
    assign seq_state    = state_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_sequencer.sv
// ============================================================================
//  Module   : tb_fetch_pc_sequencer
//  Purpose  : Directed scoreboard bench for fetch_pc_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        has_mispredict;
    logic [15:0] mispredict_pc;
    logic        jump_redirect;
    logic [15:0] jump_target;
    logic        jump_stall;
    logic        backend_stall;
    logic        bp_taken;
    logic [15:0] bp_target;
    logic [15:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_kill;
    logic [1:0]  seq_state;
    logic [15:0] redirect_cnt;

    typedef struct {
        logic [15:0] pc;
        logic        v;
        logic        k;
        logic [1:0]  s;
        logic [15:0] c;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    fetch_pc_sequencer #(
        .FETCH_WIDTH  (4),
        .FLUSH_CYCLES (2),
        .RESET_PC     (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .has_mispredict (has_mispredict),
        .mispredict_pc  (mispredict_pc),
        .jump_redirect  (jump_redirect),
        .jump_target    (jump_target),
        .jump_stall     (jump_stall),
        .backend_stall  (backend_stall),
        .bp_taken       (bp_taken),
        .bp_target      (bp_target),
        .fetch_pc       (fetch_pc),
        .fetch_valid    (fetch_valid),
        .fetch_kill     (fetch_kill),
        .seq_state      (seq_state),
        .redirect_cnt   (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        chk({tag, ".pc"},    fetch_pc,              e.pc);
        chk({tag, ".valid"}, {15'd0, fetch_valid},  {15'd0, e.v});
        chk({tag, ".kill"},  {15'd0, fetch_kill},   {15'd0, e.k});
        chk({tag, ".state"}, {14'd0, seq_state},    {14'd0, e.s});
        chk({tag, ".cnt"},   redirect_cnt,          e.c);
    endtask

    task automatic step(input logic m, input logic [15:0] mpc,
                        input logic j, input logic [15:0] jt,
                        input logic js, input logic bs,
                        input logic bp, input logic [15:0] bt,
                        input logic [15:0] e_pc, input logic e_v, input logic e_k,
                        input logic [1:0] e_s, input logic [15:0] e_c);
        exp_t e;
        exp_t got;
        has_mispredict = m;  mispredict_pc = mpc;
        jump_redirect  = j;  jump_target   = jt;
        jump_stall     = js; backend_stall = bs;
        bp_taken       = bp; bp_target     = bt;
        e.pc = e_pc; e.v = e_v; e.k = e_k; e.s = e_s; e.c = e_c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        step_no++;
        compare_all($sformatf("s%0d", step_no), got);
    endtask

    task automatic idle(input logic [15:0] e_pc, input logic e_v, input logic e_k,
                        input logic [1:0] e_s, input logic [15:0] e_c);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, e_pc, e_v, e_k, e_s, e_c);
    endtask

    initial begin
        exp_t r;
        rst = 1'b1;
        has_mispredict = 1'b0; mispredict_pc = 16'h0;
        jump_redirect  = 1'b0; jump_target   = 16'h0;
        jump_stall     = 1'b0; backend_stall = 1'b0;
        bp_taken       = 1'b0; bp_target     = 16'h0;

        #7;
        r.pc = 16'h0000; r.v = 1'b0; r.k = 1'b0; r.s = 2'd0; r.c = 16'd0;
        compare_all("reset", r);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        r.v = 1'b1;
        compare_all("release", r);

        // sequential advance
        idle(16'h0004, 1, 0, 2'd0, 16'd0);
        idle(16'h0008, 1, 0, 2'd0, 16'd0);
        idle(16'h000C, 1, 0, 2'd0, 16'd0);
        idle(16'h0010, 1, 0, 2'd0, 16'd0);

        // mispredict, two bubbles, then resume
        step(1, 16'h0100, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0100, 0, 1, 2'd2, 16'd1);
        idle(16'h0100, 0, 0, 2'd2, 16'd1);
        idle(16'h0100, 1, 0, 2'd0, 16'd1);
        idle(16'h0104, 1, 0, 2'd0, 16'd1);

        // jump stall for three cycles, then redirect (stall still high)
        step(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0104, 0, 0, 2'd1, 16'd1);
        step(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0104, 0, 0, 2'd1, 16'd1);
        step(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0104, 0, 0, 2'd1, 16'd1);
        step(0, 16'h0, 1, 16'h0200, 1, 0, 0, 16'h0, 16'h0200, 1, 1, 2'd0, 16'd2);
        idle(16'h0204, 1, 0, 2'd0, 16'd2);

        // mispredict during FLUSH reloads the counter
        step(1, 16'h0250, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0250, 0, 1, 2'd2, 16'd3);
        idle(16'h0250, 0, 0, 2'd2, 16'd3);
        step(1, 16'h0300, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0300, 0, 1, 2'd2, 16'd4);
        step(0, 16'h0, 0, 16'h0, 0, 1, 1, 16'h0777, 16'h0300, 0, 0, 2'd2, 16'd4);
        idle(16'h0300, 1, 0, 2'd0, 16'd4);
        idle(16'h0304, 1, 0, 2'd0, 16'd4);

        // simultaneous mispredict, jump redirect and prediction
        step(1, 16'h0400, 1, 16'h0500, 0, 0, 1, 16'h0600, 16'h0400, 0, 1, 2'd2, 16'd5);
        idle(16'h0400, 0, 0, 2'd2, 16'd5);
        idle(16'h0400, 1, 0, 2'd0, 16'd5);
        idle(16'h0404, 1, 0, 2'd0, 16'd5);

        // backend stall hold, predicted branches, wrap at top of address space
        step(0, 16'h0, 0, 16'h0, 0, 1, 0, 16'h0, 16'h0404, 1, 0, 2'd3, 16'd5);
        step(0, 16'h0, 0, 16'h0, 0, 1, 0, 16'h0, 16'h0404, 1, 0, 2'd3, 16'd5);
        idle(16'h0408, 1, 0, 2'd0, 16'd5);
        step(0, 16'h0, 0, 16'h0, 0, 0, 1, 16'h0A00, 16'h0A00, 1, 0, 2'd0, 16'd5);
        step(0, 16'h0, 0, 16'h0, 0, 0, 1, 16'hFFFC, 16'hFFFC, 1, 0, 2'd0, 16'd5);
        idle(16'h0000, 1, 0, 2'd0, 16'd5);
        idle(16'h0004, 1, 0, 2'd0, 16'd5);

        // jump stall dropping without a redirect keeps the PC
        step(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0004, 0, 0, 2'd1, 16'd5);
        idle(16'h0004, 1, 0, 2'd0, 16'd5);
        step(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0, 16'h0004, 0, 0, 2'd1, 16'd5);

        // asynchronous reset mid-JWAIT, with a mispredict that must lose
        #2;
        rst = 1'b1;
        has_mispredict = 1'b1; mispredict_pc = 16'h0999;
        #1;
        r.pc = 16'h0000; r.v = 1'b0; r.k = 1'b0; r.s = 2'd0; r.c = 16'd0;
        compare_all("async_rst", r);
        @(posedge clk);
        #1;
        compare_all("rst_hold", r);
        has_mispredict = 1'b0;
        jump_stall     = 1'b0;
        rst = 1'b0;
        #1;
        r.v = 1'b1;
        compare_all("release2", r);
        idle(16'h0004, 1, 0, 2'd0, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
